count_seq_ctrl: RTL and testbench
=================================

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port r, input, 1 bit, the reset; it is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: begin a count run; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port stop, input, 1 bit: abort the run and return to IDLE.
REQ-006 The block SHALL have port pause, input, 1 bit: level-sensitive hold request.
REQ-007 The block SHALL have port limit, input, WIDTH bits: terminal count value.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = one-shot, 1 = auto-reload.
REQ-009 The block SHALL have port q, output, WIDTH bits: current count.
REQ-010 The block SHALL have port qbar, output, WIDTH bits: bitwise complement of q at all times.
REQ-011 The block SHALL have port tc, output, 1 bit: terminal-count flag.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN or HOLD.
REQ-013 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-014 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, HOLD=10, DONE=11.

Function
REQ-015 The block SHALL implement a four-state FSM (IDLE, RUN, HOLD, DONE) plus an internal WIDTH-bit up counter with a latched limit (lim_q) and latched mode (mode_q).
REQ-016 The counter SHALL advance as a synchronous binary up counter: bit i toggles when enabled and all lower bits are 1; the enable is high only in RUN.
REQ-017 Per-cycle priority SHALL be: r > stop > pause > terminal-count handling > increment > start.
REQ-018 IDLE: q = 0; start=1 -> RUN next cycle, lim_q <= limit, mode_q <= mode, q stays 0 that edge.
REQ-019 RUN, q != lim_q: q <= q + 1 per cycle, wrapping 2^WIDTH-1 -> 0 only if lim_q permits (never, since q stops at lim_q).
REQ-020 RUN, q == lim_q, mode_q=0: q holds, next state DONE.
REQ-021 RUN, q == lim_q, mode_q=1: q <= 0, state stays RUN.
REQ-022 tc SHALL be combinational: 1 exactly when state=RUN and q == lim_q and pause=0 and stop=0.
REQ-023 RUN with pause=1 -> HOLD next cycle, q holds; HOLD with pause=1 stays HOLD; HOLD with pause=0 -> RUN, q holds that edge.
REQ-024 stop=1 in RUN, HOLD or DONE -> IDLE next cycle, q <= 0; stop in IDLE has no effect.
REQ-025 DONE: q holds at lim_q; start=1 -> RUN with q <= 0 and lim_q/mode_q re-latched.
REQ-026 start SHALL be ignored in RUN and HOLD; limit and mode SHALL be ignored except at the start-accept edge.
REQ-027 lim_q = 0: mode_q=0 gives one RUN cycle with tc=1 then DONE; mode_q=1 gives q=0 and tc=1 every unpaused RUN cycle.
REQ-028 start and stop asserted together in DONE SHALL resolve to IDLE (stop wins).

Reset
REQ-029 r=1 at a clock edge SHALL force state=IDLE, q=0, qbar=all ones, lim_q=0, mode_q=0, regardless of other inputs.
REQ-030 After reset: tc=0, busy=0, done=0, state=00; r asserted mid-run SHALL abort with no further tc.

Verification
REQ-031 One-shot: limit=5, mode=0, start pulse -> q 0,1,2,3,4,5 in successive RUN cycles, tc=1 on the q=5 cycle only, then done=1 with q held at 5.
REQ-032 Auto-reload: limit=3, mode=1 -> q 0,1,2,3,0,1,...; tc high every fourth cycle; busy stays 1.
REQ-033 Pause: run limit=15, pause high 3 cycles at q=6 -> state=HOLD, q stays 6 for the paused cycles, resumes 7 after release; limit changed to 2 during run has no effect.
REQ-034 Stop/reset mid-run: stop at q=9 -> next cycle IDLE, q=0; separately r at q=4 -> IDLE, q=0, qbar=1111.
REQ-035 Corners: limit=0 mode=0 -> one tc cycle then DONE; limit=15 mode=1 -> q=15 then 0 with tc; start+stop together in DONE -> IDLE.

Source files
------------

// File: rtl/count_seq_ctrl.sv
// Start/stop/pause-controlled up counter with a latched terminal limit,
// offering one-shot (stop in DONE) or auto-reload (wrap to zero) operation.
module count_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] cnt_inc;
  logic             carry;
  logic             at_lim;

  // Toggle-form increment: bit i flips when every lower bit is one.
  always_comb begin
    carry   = 1'b1;
    cnt_inc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_inc[i] = cnt_q[i] ^ carry;
      carry      = carry & cnt_q[i];
    end
  end

  assign at_lim = (cnt_q == lim_q);

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = RUN;
          lim_d   = limit;
          mode_d  = mode;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (pause) begin
          state_d = HOLD;
        end else if (at_lim) begin
          if (mode_q) cnt_d = '0;
          else        state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          lim_d   = limit;
          mode_d  = mode;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q     = cnt_q;
    qbar  = ~cnt_q;
    tc    = (state_q == RUN) && at_lim && !pause && !stop;
    busy  = (state_q == RUN) || (state_q == HOLD);
    done  = (state_q == DONE);
    state = state_q;
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed-vector bench for count_seq_ctrl: one task per scenario, each
// comparing outputs against hand-derived values one settle delay after each edge.
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       r = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, mode = 1'b0;
  logic [3:0] limit = '0;
  logic [3:0] q, qbar;
  logic       tc, busy, done;
  logic [1:0] state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  count_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .r(r), .start(start), .stop(stop), .pause(pause),
    .limit(limit), .mode(mode), .q(q), .qbar(qbar), .tc(tc),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1; start = 1'b1; limit = 4'd7; mode = 1'b1;
    tick();
    r = 1'b0; start = 1'b0;
    total_cnt++; if (state !== 2'b00) $display("FAIL reset_state got %b want 00", state); else pass_cnt++;
    total_cnt++; if (q !== 4'd0) $display("FAIL reset_q got %0d want 0", q); else pass_cnt++;
    total_cnt++; if (qbar !== 4'b1111) $display("FAIL reset_qbar got %b want 1111", qbar); else pass_cnt++;
    total_cnt++; if ({tc, busy, done} !== 3'b000) $display("FAIL reset_flags got %b want 000", {tc, busy, done}); else pass_cnt++;
  endtask

  task automatic test_oneshot();
    limit = 4'd5; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      total_cnt++; if (q !== 4'(k)) $display("FAIL oneshot_q k=%0d got %0d want %0d", k, q, k); else pass_cnt++;
      total_cnt++; if (tc !== (k == 5)) $display("FAIL oneshot_tc k=%0d got %b want %b", k, tc, (k == 5)); else pass_cnt++;
      total_cnt++; if (state !== 2'b01) $display("FAIL oneshot_state k=%0d got %b want 01", k, state); else pass_cnt++;
      tick();
    end
    total_cnt++; if ({done, busy, tc} !== 3'b100) $display("FAIL oneshot_done got %b want 100", {done, busy, tc}); else pass_cnt++;
    total_cnt++; if (q !== 4'd5) $display("FAIL oneshot_hold got %0d want 5", q); else pass_cnt++;
    tick();
    total_cnt++; if (q !== 4'd5 || state !== 2'b11) $display("FAIL oneshot_hold2 got q=%0d st=%b want q=5 st=11", q, state); else pass_cnt++;
  endtask

  task automatic test_autoreload();
    limit = 4'd3; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; limit = 4'd9; mode = 1'b0;
    for (int k = 0; k < 10; k++) begin
      total_cnt++; if (q !== 4'(k % 4)) $display("FAIL auto_q k=%0d got %0d want %0d", k, q, k % 4); else pass_cnt++;
      total_cnt++; if (tc !== ((k % 4) == 3)) $display("FAIL auto_tc k=%0d got %b want %b", k, tc, ((k % 4) == 3)); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL auto_busy k=%0d got %b want 1", k, busy); else pass_cnt++;
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total_cnt++; if (state !== 2'b00 || q !== 4'd0) $display("FAIL auto_stop got st=%b q=%0d want st=00 q=0", state, q); else pass_cnt++;
  endtask

  task automatic test_pause_stop();
    limit = 4'd15; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; limit = 4'd2;
    repeat (6) tick();
    total_cnt++; if (q !== 4'd6) $display("FAIL pause_pre got %0d want 6", q); else pass_cnt++;
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++; if (state !== 2'b10 || q !== 4'd6) $display("FAIL pause_hold k=%0d got st=%b q=%0d want st=10 q=6", k, state, q); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1 || tc !== 1'b0) $display("FAIL pause_flags k=%0d got busy=%b tc=%b want 1 0", k, busy, tc); else pass_cnt++;
    end
    pause = 1'b0;
    tick();
    total_cnt++; if (state !== 2'b01 || q !== 4'd6) $display("FAIL pause_resume got st=%b q=%0d want st=01 q=6", state, q); else pass_cnt++;
    tick();
    total_cnt++; if (q !== 4'd7) $display("FAIL pause_next got %0d want 7", q); else pass_cnt++;
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    total_cnt++; if (q !== 4'd9 || state !== 2'b01) $display("FAIL start_ignored got q=%0d st=%b want q=9 st=01", q, state); else pass_cnt++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total_cnt++; if (state !== 2'b00 || q !== 4'd0 || qbar !== 4'b1111) $display("FAIL stop_mid got st=%b q=%0d qbar=%b want 00 0 1111", state, q, qbar); else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    limit = 4'd10; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    total_cnt++; if (q !== 4'd4) $display("FAIL rmid_pre got %0d want 4", q); else pass_cnt++;
    r = 1'b1;
    tick();
    r = 1'b0;
    total_cnt++; if (state !== 2'b00 || q !== 4'd0 || qbar !== 4'b1111) $display("FAIL rmid got st=%b q=%0d qbar=%b want 00 0 1111", state, q, qbar); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if ({tc, busy, state} !== 4'b0000) $display("FAIL rmid_quiet got %b want 0000", {tc, busy, state}); else pass_cnt++;
  endtask

  task automatic test_corners();
    limit = 4'd0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if (tc !== 1'b1 || q !== 4'd0) $display("FAIL lim0_tc got tc=%b q=%0d want 1 0", tc, q); else pass_cnt++;
    tick();
    total_cnt++; if (state !== 2'b11 || tc !== 1'b0) $display("FAIL lim0_done got st=%b tc=%b want 11 0", state, tc); else pass_cnt++;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total_cnt++; if (state !== 2'b00) $display("FAIL start_stop got %b want 00", state); else pass_cnt++;
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (tc !== 1'b1 || q !== 4'd0 || state !== 2'b01) $display("FAIL lim0_auto k=%0d got tc=%b q=%0d st=%b", k, tc, q, state); else pass_cnt++;
      tick();
    end
    pause = 1'b1;
    #1;
    total_cnt++; if (tc !== 1'b0) $display("FAIL tc_pause got %b want 0", tc); else pass_cnt++;
    pause = 1'b0; stop = 1'b1;
    #1;
    total_cnt++; if (tc !== 1'b0) $display("FAIL tc_stop got %b want 0", tc); else pass_cnt++;
    tick();
    stop = 1'b0;
    limit = 4'd15; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    total_cnt++; if (q !== 4'd15 || tc !== 1'b1) $display("FAIL lim15_top got q=%0d tc=%b want 15 1", q, tc); else pass_cnt++;
    tick();
    total_cnt++; if (q !== 4'd0 || tc !== 1'b0 || state !== 2'b01) $display("FAIL lim15_wrap got q=%0d tc=%b st=%b want 0 0 01", q, tc, state); else pass_cnt++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    limit = 4'd1; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    total_cnt++; if (state !== 2'b11 || q !== 4'd1) $display("FAIL b2b_done got st=%b q=%0d want 11 1", state, q); else pass_cnt++;
    limit = 4'd2; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    total_cnt++; if (state !== 2'b01 || q !== 4'd0) $display("FAIL b2b_restart got st=%b q=%0d want 01 0", state, q); else pass_cnt++;
    repeat (2) tick();
    total_cnt++; if (q !== 4'd2 || tc !== 1'b1) $display("FAIL b2b_relatch got q=%0d tc=%b want 2 1", q, tc); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done2 got %b want 1", done); else pass_cnt++;
  endtask

  initial begin
    tick();
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause_stop();
    test_reset_midrun();
    test_corners();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
